// File: rtl/ctrl_pkg.sv
// Shared constants and stage records for the control pipeline.
// Latency: none (types, constants and one pure helper function).
// Backpressure: not applicable.
package ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int ALU_CW = 4;

  localparam logic [ALU_CW-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CW-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CW-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CW-1:0] ALU_SLLV = 4'b0011;
  localparam logic [ALU_CW-1:0] ALU_SRLV = 4'b0101;
  localparam logic [ALU_CW-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CW-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CW-1:0] ALU_SRAV = 4'b1000;

  // Everything the execute stage needs from decode.
  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regdst;
    logic              valid;
    logic [ALU_CW-1:0] aluctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } e_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              valid;
    logic [REG_AW-1:0] writereg;
  } m_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              valid;
    logic [REG_AW-1:0] writereg;
  } w_stage_t;

  // R-type instructions write rd, immediates/loads write rt.
  function automatic logic [REG_AW-1:0] dest_reg(input logic regdst,
                                                 input logic [REG_AW-1:0] rt,
                                                 input logic [REG_AW-1:0] rd);
    return regdst ? rd : rt;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: decode inputs, hazard controls, E/M/W outputs.
// Latency: none (wires only).
// Backpressure: StallAll freezes the pipe; FlushE bubbles the E stage.
interface ctrl_pipe_if;
  import ctrl_pkg::*;

  logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ValidD;
  logic [ALU_CW-1:0] ALUControlD;
  logic [REG_AW-1:0] RsD, RtD, RdD;
  logic              FlushE, StallAll;

  logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
  logic [ALU_CW-1:0] ALUControlE;
  logic [REG_AW-1:0] RsE, RtE, RdE, WriteRegE;

  logic              RegWriteM, MemtoRegM, MemWriteM, ValidM;
  logic [REG_AW-1:0] WriteRegM;

  logic              RegWriteW, MemtoRegW, ValidW;
  logic [REG_AW-1:0] WriteRegW;

  logic [31:0]       RetireCount;

  modport master (
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ValidD,
           ALUControlD, RsD, RtD, RdD, FlushE, StallAll,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE,
           ALUControlE, RsE, RtE, RdE, WriteRegE,
           RegWriteM, MemtoRegM, MemWriteM, ValidM, WriteRegM,
           RegWriteW, MemtoRegW, ValidW, WriteRegW, RetireCount
  );

  modport slave (
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ValidD,
           ALUControlD, RsD, RtD, RdD, FlushE, StallAll,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE,
           ALUControlE, RsE, RtE, RdE, WriteRegE,
           RegWriteM, MemtoRegM, MemWriteM, ValidM, WriteRegM,
           RegWriteW, MemtoRegW, ValidW, WriteRegW, RetireCount
  );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with enable and synchronous clear.
// Latency: 1 cycle from d to q when en=1.
// Backpressure: en=0 holds; clr only acts on an enabled edge, so a hold beats a clear.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  // Next value: hold when disabled, otherwise load a bubble or the new data.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? '0 : d;
    end
  end

  // State register; reset wins over enable and clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline D->E->M->W with a retired-instruction counter.
// Latency: D fields reach E after 1 edge, M after 2, W after 3.
// Backpressure: StallAll freezes E/M/W and the counter; FlushE bubbles E when not stalled.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  e_stage_t          e_d, e_q;
  m_stage_t          m_d, m_q;
  w_stage_t          w_d, w_q;
  logic [REG_AW-1:0] write_reg_e;
  logic [31:0]       retire_cnt_d, retire_cnt_q;
  logic              adv;

  assign adv = ~bus.StallAll;

  // Decode fields into the E record; a non-valid slot can never write.
  always_comb begin
    e_d          = '0;
    e_d.valid    = bus.ValidD;
    e_d.regwrite = bus.RegWriteD & bus.ValidD;
    e_d.memwrite = bus.MemWriteD & bus.ValidD;
    e_d.memtoreg = bus.MemtoRegD;
    e_d.alusrc   = bus.ALUSrcD;
    e_d.regdst   = bus.RegDstD;
    e_d.aluctrl  = bus.ALUControlD;
    e_d.rs       = bus.RsD;
    e_d.rt       = bus.RtD;
    e_d.rd       = bus.RdD;
  end

  pipe_reg #(.W($bits(e_stage_t))) u_e_reg (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .clr (bus.FlushE),
    .d   (e_d),
    .q   (e_q)
  );

  assign write_reg_e = dest_reg(e_q.regdst, e_q.rt, e_q.rd);

  // E record into the M record, re-gating writes on the slot's valid bit.
  always_comb begin
    m_d          = '0;
    m_d.valid    = e_q.valid;
    m_d.regwrite = e_q.regwrite & e_q.valid;
    m_d.memwrite = e_q.memwrite & e_q.valid;
    m_d.memtoreg = e_q.memtoreg;
    m_d.writereg = write_reg_e;
  end

  pipe_reg #(.W($bits(m_stage_t))) u_m_reg (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .clr (1'b0),
    .d   (m_d),
    .q   (m_q)
  );

  // M record into the W record; memory write has no meaning past M.
  always_comb begin
    w_d          = '0;
    w_d.valid    = m_q.valid;
    w_d.regwrite = m_q.regwrite & m_q.valid;
    w_d.memtoreg = m_q.memtoreg;
    w_d.writereg = m_q.writereg;
  end

  pipe_reg #(.W($bits(w_stage_t))) u_w_reg (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .clr (1'b0),
    .d   (w_d),
    .q   (w_q)
  );

  // An instruction retires when it leaves a valid W slot on a moving edge.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (adv && w_q.valid) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // Retire counter register; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.RegWriteE   = e_q.regwrite;
  assign bus.MemtoRegE   = e_q.memtoreg;
  assign bus.MemWriteE   = e_q.memwrite;
  assign bus.ALUSrcE     = e_q.alusrc;
  assign bus.RegDstE     = e_q.regdst;
  assign bus.ValidE      = e_q.valid;
  assign bus.ALUControlE = e_q.aluctrl;
  assign bus.RsE         = e_q.rs;
  assign bus.RtE         = e_q.rt;
  assign bus.RdE         = e_q.rd;
  assign bus.WriteRegE   = write_reg_e;

  assign bus.RegWriteM   = m_q.regwrite;
  assign bus.MemtoRegM   = m_q.memtoreg;
  assign bus.MemWriteM   = m_q.memwrite;
  assign bus.ValidM      = m_q.valid;
  assign bus.WriteRegM   = m_q.writereg;

  assign bus.RegWriteW   = w_q.regwrite;
  assign bus.MemtoRegW   = w_q.memtoreg;
  assign bus.ValidW      = w_q.valid;
  assign bus.WriteRegW   = w_q.writereg;

  assign bus.RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic.
// Latency: expects W output 3 moving edges after issue, retire on the next moving edge.
// Backpressure: drives StallAll/FlushE/rst directly and models their effect.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_pipe_if bus();

  ctrl_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected W-stage appearance of one issued instruction.
  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  wr;
    int unsigned adv;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned adv_cnt    = 0;
  bit          fresh      = 1'b0;
  bit          pending    = 1'b0;
  logic [31:0] exp_retire = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_d(input logic rw, input logic m2r, input logic mw, input logic as,
                       input logic rdst, input logic v, input logic [3:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.RegWriteD   = rw;
    bus.MemtoRegD   = m2r;
    bus.MemWriteD   = mw;
    bus.ALUSrcD     = as;
    bus.RegDstD     = rdst;
    bus.ValidD      = v;
    bus.ALUControlD = alu;
    bus.RsD         = rs;
    bus.RtD         = rt;
    bus.RdD         = rd;
  endtask

  task automatic idle();
    set_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Drive one decode slot; record the expected W result if it will enter the pipe.
  task automatic issue(input logic rw, input logic m2r, input logic mw, input logic as,
                       input logic rdst, input logic v, input logic [3:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    set_d(rw, m2r, mw, as, rdst, v, alu, rs, rt, rd);
    if (v && !bus.FlushE && !bus.StallAll && !rst) begin
      e.rw  = rw;
      e.m2r = m2r;
      e.wr  = rdst ? rd : rt;
      e.adv = adv_cnt + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_e"}, {2'b0, bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE,
                      bus.RegDstE, bus.ValidE, bus.ALUControlE, bus.RsE, bus.RtE,
                      bus.RdE, bus.WriteRegE}, 32'd0);
    chk({tag, "_m"}, {23'b0, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ValidM,
                      bus.WriteRegM}, 32'd0);
    chk({tag, "_w"}, {24'b0, bus.RegWriteW, bus.MemtoRegW, bus.ValidW, bus.WriteRegW}, 32'd0);
  endtask

  // Edge bookkeeping: what the pipe does at each rising edge, from the inputs alone.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        pending    = 1'b0;
        exp_retire = 32'd0;
        fresh      = 1'b0;
      end else if (!bus.StallAll) begin
        if (pending) exp_retire = exp_retire + 32'd1;
        pending = 1'b0;
        adv_cnt++;
        fresh = 1'b1;
      end else begin
        fresh = 1'b0;
      end
    end
  end

  // Monitor: compares the retire counter every cycle and pops each new W instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("retire_count", bus.RetireCount, exp_retire);
      if (!bus.ValidW) begin
        chk("w_bubble_regwrite", {31'b0, bus.RegWriteW}, 32'd0);
      end else if (fresh) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_unexpected: got valid W reg %0d expected no instruction", bus.WriteRegW);
        end else begin
          e = exp_q.pop_front();
          chk("w_regwrite", {31'b0, bus.RegWriteW}, {31'b0, e.rw});
          chk("w_memtoreg", {31'b0, bus.MemtoRegW}, {31'b0, e.m2r});
          chk("w_writereg", {27'b0, bus.WriteRegW}, {27'b0, e.wr});
          chk("w_latency", adv_cnt, e.adv + 2);
          pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.FlushE   = 1'b0;
    bus.StallAll = 1'b0;
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    chk_all_zero("reset");
    chk("reset_retire", bus.RetireCount, 32'd0);
    rst = 1'b0;

    // addi $8
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD, 5'd1, 5'd8, 5'd0);
    cycle();
    chk("addi_regwrite_e", {31'b0, bus.RegWriteE}, 32'd1);
    chk("addi_writereg_e", {27'b0, bus.WriteRegE}, 32'd8);
    idle();
    cycle();
    chk("addi_writereg_m", {27'b0, bus.WriteRegM}, 32'd8);
    cycle();
    chk("addi_regwrite_w", {31'b0, bus.RegWriteW}, 32'd1);
    chk("addi_writereg_w", {27'b0, bus.WriteRegW}, 32'd8);
    cycle();
    chk("addi_retired", bus.RetireCount, 32'd1);

    // R-type sub $9 = $x - $3
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_SUB, 5'd2, 5'd3, 5'd9);
    cycle();
    chk("rtype_writereg_e", {27'b0, bus.WriteRegE}, 32'd9);
    chk("rtype_aluctrl_e", {28'b0, bus.ALUControlE}, 32'b0110);
    idle();
    repeat (3) cycle();
    chk("rtype_retired", bus.RetireCount, 32'd2);

    // sw flushed in decode
    bus.FlushE = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD, 5'd4, 5'd5, 5'd0);
    cycle();
    chk_all_zero("flush");
    bus.FlushE = 1'b0;
    idle();
    cycle();
    chk("flush_memwrite_m", {31'b0, bus.MemWriteM}, 32'd0);
    cycle();
    chk("flush_memwrite_m2", {31'b0, bus.MemWriteM}, 32'd0);
    chk("flush_retire", bus.RetireCount, 32'd2);

    // lw $10 held by a stall that also asserts flush
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD, 5'd6, 5'd10, 5'd0);
    cycle();
    bus.StallAll = 1'b1;
    bus.FlushE   = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD, 5'd7, 5'd11, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid_e", {31'b0, bus.ValidE}, 32'd1);
      chk("stall_memtoreg_e", {31'b0, bus.MemtoRegE}, 32'd1);
      chk("stall_writereg_e", {27'b0, bus.WriteRegE}, 32'd10);
      chk("stall_valid_m", {31'b0, bus.ValidM}, 32'd0);
      chk("stall_valid_w", {31'b0, bus.ValidW}, 32'd0);
      chk("stall_retire", bus.RetireCount, 32'd2);
    end
    bus.StallAll = 1'b0;
    bus.FlushE   = 1'b0;
    idle();
    cycle();
    chk("lw_valid_m", {31'b0, bus.ValidM}, 32'd1);
    chk("lw_writereg_m", {27'b0, bus.WriteRegM}, 32'd10);
    cycle();
    chk("lw_valid_w", {31'b0, bus.ValidW}, 32'd1);
    chk("lw_memtoreg_w", {31'b0, bus.MemtoRegW}, 32'd1);
    cycle();
    chk("lw_retired", bus.RetireCount, 32'd3);

    // reset with three instructions in flight
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_OR, 5'd1, 5'd2, 5'(12 + i));
      cycle();
    end
    rst = 1'b1;
    idle();
    cycle();
    chk_all_zero("midrst");
    chk("midrst_retire", bus.RetireCount, 32'd0);
    rst = 1'b0;
    repeat (4) cycle();
    chk("midrst_none_retired", bus.RetireCount, 32'd0);

    // counter wrap
    #2;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    exp_retire = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_SLT, 5'd3, 5'd20, 5'd0);
    cycle();
    idle();
    repeat (3) cycle();
    chk("wrap_retire", bus.RetireCount, 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      bus.StallAll = ($urandom_range(0, 7) == 0);
      bus.FlushE   = ($urandom_range(0, 7) == 0);
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom));
      cycle();
    end
    rst          = 1'b0;
    bus.StallAll = 1'b0;
    bus.FlushE   = 1'b0;
    idle();
    repeat (5) cycle();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 Inputs, decode stage, 1 bit each: RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ValidD.
REQ-005 Inputs, decode stage: ALUControlD 4 bits, and RsD, RtD, RdD 5 bits each.
REQ-006 Port FlushE, input, 1 bit: turns the next E-stage contents into a bubble (load-use or branch).
REQ-007 Port StallAll, input, 1 bit: freezes the E, M and W registers and the retire counter.
REQ-008 E-stage outputs SHALL be: RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE (1 bit each); ALUControlE (4 bits); RsE, RtE, RdE, WriteRegE (5 bits each).
REQ-009 M-stage outputs SHALL be: RegWriteM, MemtoRegM, MemWriteM, ValidM (1 bit each); WriteRegM (5 bits).
REQ-010 W-stage outputs SHALL be: RegWriteW, MemtoRegW, ValidW (1 bit each); WriteRegW (5 bits).
REQ-011 Port RetireCount, output, 32 bits: count of instructions that reached W with ValidW=1.

Function
REQ-012 With StallAll=0 and FlushE=0, D inputs sampled at edge k SHALL appear on the E outputs after edge k, on M after edge k+1, and on W after edge k+2.
REQ-013 WriteRegE SHALL be combinational: RdE when RegDstE=1, else RtE.
REQ-014 WriteRegM SHALL register WriteRegE, and WriteRegW SHALL register WriteRegM.
REQ-015 With FlushE=1 and StallAll=0, the E register SHALL load all zeros at the edge (a bubble); M and W SHALL advance normally.
REQ-016 With StallAll=1, the E, M, W registers and RetireCount SHALL hold, and FlushE SHALL be ignored (stall has priority over flush).
REQ-017 The stored RegWrite and MemWrite of a stage SHALL be forced to 0 whenever that stage's Valid is 0, so a bubble never writes.
REQ-018 A write to register 0 SHALL NOT be suppressed here; hazard and regfile logic handle it.
REQ-019 RetireCount SHALL increment by 1 at each unstalled edge where ValidW=1 before the edge.
REQ-020 RetireCount SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 ALUControlE SHALL carry the 4-bit encodings unchanged: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 0011 sllv, 0101 srlv, 1000 srav.

Reset
REQ-022 While rst=1 at a rising edge, every E, M and W register SHALL load 0, so all outputs read 0 and WriteRegE reads 0.
REQ-023 While rst=1 at a rising edge, RetireCount SHALL load 0.
REQ-024 Reset SHALL override StallAll and FlushE.
REQ-025 A reset asserted mid-operation SHALL discard all in-flight instructions without retiring them.

Structure
REQ-026 Shared package ctrl_pkg SHALL hold the ALU control encodings as named constants, the register-address width (5), and the ALUControl width (4).
REQ-027 One sub-module pipe_reg SHALL be used: a parameterised-width register with en and synchronous clr, instantiated once per stage.

Verification
REQ-028 After reset, send addi (RegWriteD=1, ALUSrcD=1, RegDstD=0, RtD=8, ValidD=1) -> cycle 1: RegWriteE=1, WriteRegE=8; cycle 2: WriteRegM=8; cycle 3: RegWriteW=1, WriteRegW=8; then RetireCount=1.
REQ-029 R-type (RegDstD=1, RdD=9, RtD=3, ALUControlD=0110) -> WriteRegE=9 and ALUControlE=0110.
REQ-030 sw with FlushE=1 on its D cycle (MemWriteD=1) -> E holds all zeros; MemWriteM stays 0 two cycles later; RetireCount unchanged.
REQ-031 StallAll=1 for 3 cycles with FlushE=1 simultaneously and a lw in E -> E/M/W and RetireCount frozen for 3 cycles; after release the lw continues, is not flushed, and retires.
REQ-032 Preload RetireCount to 0xFFFFFFFF via a force, then retire one instruction -> RetireCount=0.
REQ-033 Assert rst with 3 valid instructions in flight -> the next cycle has all outputs 0, RetireCount=0, and none of them retire.
